// File: rtl/pipeline_control_unit_pkg.sv
// Shared definitions for the pipeline control unit: FSM state encoding and
// the default write-back drain depth.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_DONE      = 3'd4
    } ctrl_state_t;

    localparam int N_DRAIN_DEF = 3;

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Datapath-facing bundle of the control unit: hazard inputs from ID/ID-EX and
// the stage enable/bubble/flush outputs back to the pipeline registers.
interface pipeline_ctrl_if #(
    parameter int NB_REG = 5
);
    logic [NB_REG-1:0] id_rs_i;
    logic [NB_REG-1:0] id_rt_i;
    logic [NB_REG-1:0] ex_rt_i;
    logic              ex_mem_read_i;
    logic              branch_taken_i;
    logic              halt_ex_i;

    logic              pc_en_o;
    logic              ifid_en_o;
    logic              pipe_en_o;
    logic              idex_bubble_o;
    logic              ifid_flush_o;

    modport master (
        input  id_rs_i, id_rt_i, ex_rt_i, ex_mem_read_i, branch_taken_i, halt_ex_i,
        output pc_en_o, ifid_en_o, pipe_en_o, idex_bubble_o, ifid_flush_o
    );

    modport slave (
        output id_rs_i, id_rt_i, ex_rt_i, ex_mem_read_i, branch_taken_i, halt_ex_i,
        input  pc_en_o, ifid_en_o, pipe_en_o, idex_bubble_o, ifid_flush_o
    );
endinterface

// File: rtl/pipeline_control_unit_hazard.sv
// Load-use detector: a load sitting in ID/EX whose destination is read by the
// instruction in ID. Register 0 never creates a dependency.
module hazard_detection_unit #(
    parameter int NB_REG = 5
) (
    input  logic              i_ex_mem_read,
    input  logic [NB_REG-1:0] i_ex_rt,
    input  logic [NB_REG-1:0] i_id_rs,
    input  logic [NB_REG-1:0] i_id_rt,
    output logic              o_load_use
);
    assign o_load_use = i_ex_mem_read && (i_ex_rt != '0) &&
                        ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
endmodule

// File: rtl/pipeline_control_unit.sv
// Central sequencer for the five-stage pipeline: run/step FSM, hazard-driven
// stall/bubble/flush generation, halt drain and an enabled-cycle counter.
module pipeline_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int NB_REG   = 5,
    parameter int N_DRAIN  = N_DRAIN_DEF,
    parameter int NB_CYCLE = 32
) (
    input  logic                clock,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                step_mode_i,
    input  logic                step_i,
    pipeline_ctrl_if.master     bus,
    output logic                running_o,
    output logic                done_o,
    output logic [NB_CYCLE-1:0] cycle_count_o
);
    localparam int NB_DRAIN = (N_DRAIN > 1) ? $clog2(N_DRAIN) : 1;

    ctrl_state_t         r_state;
    ctrl_state_t         w_next_state;
    logic [NB_DRAIN-1:0] r_drain_cnt;
    logic [NB_CYCLE-1:0] r_cycle_cnt;

    logic w_load_use;
    logic w_active;
    logic w_stall;
    logic w_drain_load;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_pipe_en;
    logic w_bubble;
    logic w_flush;

    hazard_detection_unit #(
        .NB_REG (NB_REG)
    ) u_hazard (
        .i_ex_mem_read (bus.ex_mem_read_i),
        .i_ex_rt       (bus.ex_rt_i),
        .i_id_rs       (bus.id_rs_i),
        .i_id_rt       (bus.id_rt_i),
        .o_load_use    (w_load_use)
    );

    assign w_active = (r_state == ST_RUN) || ((r_state == ST_STEP_WAIT) && step_i);
    // Halt outranks load-use, which outranks a taken branch.
    assign w_stall  = w_load_use || bus.halt_ex_i;

    always_comb begin
        w_next_state = r_state;
        w_drain_load = 1'b0;
        w_pc_en      = 1'b0;
        w_ifid_en    = 1'b0;
        w_pipe_en    = 1'b0;
        w_bubble     = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_next_state = step_mode_i ? ST_STEP_WAIT : ST_RUN;
                end
            end
            ST_RUN, ST_STEP_WAIT: begin
                if (w_active) begin
                    w_pipe_en = 1'b1;
                    w_pc_en   = !w_stall;
                    w_ifid_en = !w_stall;
                    w_bubble  = w_stall;
                    w_flush   = bus.branch_taken_i && !w_stall;
                    if (bus.halt_ex_i) begin
                        w_next_state = ST_DRAIN;
                        w_drain_load = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                w_pipe_en = 1'b1;
                w_bubble  = 1'b1;
                if (r_drain_cnt == '0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_DONE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_i) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            // Counter holds N_DRAIN-1 on entry so DRAIN spans exactly N_DRAIN cycles.
            if (w_drain_load) begin
                r_drain_cnt <= NB_DRAIN'(N_DRAIN - 1);
            end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
                r_drain_cnt <= r_drain_cnt - 1'b1;
            end
            if (w_pipe_en && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_en_o       = w_pc_en;
    assign bus.ifid_en_o     = w_ifid_en;
    assign bus.pipe_en_o     = w_pipe_en;
    assign bus.idex_bubble_o = w_bubble;
    assign bus.ifid_flush_o  = w_flush;

    assign running_o     = (r_state == ST_RUN) || (r_state == ST_STEP_WAIT) ||
                           (r_state == ST_DRAIN);
    assign done_o        = (r_state == ST_DONE);
    assign cycle_count_o = r_cycle_cnt;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: directed scenarios, a behavioural model
// compared every cycle, and literal checks that pin the model.
module tb_pipeline_control_unit;
    localparam int NB_REG   = 5;
    localparam int N_DRAIN  = 3;
    localparam int NB_CYCLE = 4;
    localparam int CMAX     = (1 << NB_CYCLE) - 1;

    logic                clock;
    logic                reset_i;
    logic                start_i;
    logic                step_mode_i;
    logic                step_i;
    logic                running_o;
    logic                done_o;
    logic [NB_CYCLE-1:0] cycle_count_o;

    pipeline_ctrl_if #(.NB_REG(NB_REG)) pif ();

    pipeline_control_unit #(
        .NB_REG   (NB_REG),
        .N_DRAIN  (N_DRAIN),
        .NB_CYCLE (NB_CYCLE)
    ) dut (
        .clock         (clock),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .step_mode_i   (step_mode_i),
        .step_i        (step_i),
        .bus           (pif.master),
        .running_o     (running_o),
        .done_o        (done_o),
        .cycle_count_o (cycle_count_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Model: started/step flags, drain cycles still to go, finished flag, count.
    bit m_started    = 1'b0;
    bit m_step       = 1'b0;
    bit m_done       = 1'b0;
    int m_drain_left = 0;
    int m_count      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Vector order: {pc_en, ifid_en, pipe_en, bubble, flush, running, done}
    function automatic logic [6:0] model_out();
        logic lu;
        logic stall;
        logic [6:0] v;
        lu = pif.ex_mem_read_i && (pif.ex_rt_i != 0) &&
             (pif.ex_rt_i == pif.id_rs_i || pif.ex_rt_i == pif.id_rt_i);
        stall = lu || pif.halt_ex_i;
        v = '0;
        if (m_done) begin
            v[0] = 1'b1;
        end else if (m_drain_left > 0) begin
            v = 7'b0011010;
        end else if (m_started) begin
            v[1] = 1'b1;
            if (!m_step || step_i) begin
                v[6] = !stall;
                v[5] = !stall;
                v[4] = 1'b1;
                v[3] = stall;
                v[2] = pif.branch_taken_i && !stall;
            end
        end
        return v;
    endfunction

    function automatic logic [6:0] dut_out();
        return {pif.pc_en_o, pif.ifid_en_o, pif.pipe_en_o, pif.idex_bubble_o,
                pif.ifid_flush_o, running_o, done_o};
    endfunction

    always @(posedge clock) begin
        logic [6:0] e;
        e = model_out();
        if (!reset_i) begin
            m_started    <= 1'b0;
            m_step       <= 1'b0;
            m_done       <= 1'b0;
            m_drain_left <= 0;
            m_count      <= 0;
        end else begin
            if (e[4] && m_count < CMAX) m_count <= m_count + 1;
            if (!m_started) begin
                if (start_i) begin
                    m_started <= 1'b1;
                    m_step    <= step_mode_i;
                end
            end else if (m_drain_left > 0) begin
                if (m_drain_left == 1) m_done <= 1'b1;
                m_drain_left <= m_drain_left - 1;
            end else if (e[4] && pif.halt_ex_i) begin
                m_drain_left <= N_DRAIN;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("outputs", int'(dut_out()), int'(model_out()));
            chk("cycle_count", int'(cycle_count_o), m_count);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_hz();
        pif.ex_mem_read_i  = 1'b0;
        pif.ex_rt_i        = '0;
        pif.id_rs_i        = '0;
        pif.id_rt_i        = '0;
        pif.branch_taken_i = 1'b0;
        pif.halt_ex_i      = 1'b0;
    endtask

    task automatic set_lu(input int rt, input int rs, input int rt2);
        pif.ex_mem_read_i = 1'b1;
        pif.ex_rt_i       = NB_REG'(rt);
        pif.id_rs_i       = NB_REG'(rs);
        pif.id_rt_i       = NB_REG'(rt2);
    endtask

    initial begin
        reset_i = 1'b0; start_i = 1'b0; step_mode_i = 1'b0; step_i = 1'b0;
        clear_hz();
        tick(); tick();
        chk_en = 1'b1;
        chk("reset_outputs", int'(dut_out()), 0);
        chk("reset_count", int'(cycle_count_o), 0);
        reset_i = 1'b1;
        tick();

        // Continuous run, no hazards
        start_i = 1'b1; tick(); start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1 chk("run_enables", int'({pif.pc_en_o, pif.ifid_en_o, pif.pipe_en_o}), 7);
            tick();
        end
        chk("run_count10", int'(cycle_count_o), 10);
        chk("model_count10", m_count, 10);

        // Load-use on rs, then same with rt=0, then on rt
        set_lu(5, 5, 0); #1;
        chk("lu_stall", int'(dut_out()), 7'b0011010);
        tick();
        set_lu(0, 0, 0); #1;
        chk("lu_r0_nostall", int'(dut_out()), 7'b1110010);
        tick();
        set_lu(7, 3, 7); #1;
        chk("lu_rt_stall", int'({pif.pc_en_o, pif.idex_bubble_o}), 1);
        tick();
        clear_hz();

        // Branch alone, branch with load-use, then branch re-evaluated
        pif.branch_taken_i = 1'b1; #1;
        chk("branch_flush", int'(pif.ifid_flush_o), 1);
        tick();
        set_lu(9, 9, 1); #1;
        chk("branch_lu", int'({pif.ifid_flush_o, pif.pc_en_o, pif.idex_bubble_o}), 1);
        tick();
        pif.ex_mem_read_i = 1'b0; #1;
        chk("branch_retry", int'(pif.ifid_flush_o), 1);
        tick();
        clear_hz();

        // step_i in RUN is ignored; counter saturates
        step_i = 1'b1; tick(); tick(); step_i = 1'b0;
        chk("count_sat", int'(cycle_count_o), CMAX);

        // Halt with load-use and branch present: halt wins
        pif.halt_ex_i = 1'b1; pif.branch_taken_i = 1'b1; set_lu(4, 4, 0); #1;
        chk("halt_cycle", int'(dut_out()), 7'b0011010);
        tick();
        clear_hz();
        for (int i = 0; i < N_DRAIN; i++) begin
            chk("drain", int'(dut_out()), 7'b0011010);
            tick();
        end
        chk("done", int'(dut_out()), 7'b0000001);
        start_i = 1'b1; step_i = 1'b1; tick(); start_i = 1'b0; step_i = 1'b0; tick();
        chk("done_hold", int'(dut_out()), 7'b0000001);

        // Step mode
        reset_i = 1'b0; tick(); reset_i = 1'b1;
        start_i = 1'b1; step_mode_i = 1'b1; tick(); start_i = 1'b0; step_mode_i = 1'b0;
        set_lu(6, 6, 6); #1;
        chk("step_wait_idle", int'(dut_out()), 7'b0000010);
        tick();
        clear_hz();
        for (int i = 0; i < 3; i++) begin
            step_i = 1'b1; #1;
            chk("step_pulse", int'(pif.pipe_en_o), 1);
            tick();
            step_i = 1'b0; tick();
        end
        chk("step_count3", int'(cycle_count_o), 3);
        chk("model_step3", m_count, 3);
        step_i = 1'b1; tick(); tick(); step_i = 1'b0; tick();
        chk("step_held2", int'(cycle_count_o), 5);

        // Halt during a step, then reset on the second drain cycle
        step_i = 1'b1; pif.halt_ex_i = 1'b1; tick();
        step_i = 1'b0; pif.halt_ex_i = 1'b0;
        tick();
        chk("drain2", int'(dut_out()), 7'b0011010);
        reset_i = 1'b0; tick();
        chk("reset_mid_drain", int'(dut_out()), 0);
        chk("reset_mid_drain_cnt", int'(cycle_count_o), 0);
        reset_i = 1'b1;
        tick(); tick();
        chk("idle_after_reset", int'(dut_out()), 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
